// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - op-select, opcode/funct and sizing constants for the instruction encoder
package instr_encoder_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = 2;
    localparam int CNT_W      = 3;
    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 32;

    typedef enum logic {FMT_R, FMT_I} fmt_e;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_SLT   = 4'd4;
    localparam logic [3:0] OP_LW    = 4'd5;
    localparam logic [3:0] OP_SW    = 4'd6;
    localparam logic [3:0] OP_BEQ   = 4'd7;
    localparam logic [3:0] OP_BN    = 4'd8;
    localparam logic [3:0] OP_BALRZ = 4'd9;
    localparam logic [3:0] OP_JR    = 4'd10;
    localparam logic [3:0] OP_JRSAL = 4'd11;
    localparam logic [3:0] OP_JMADD = 4'd12;
    localparam logic [3:0] OP_BALMN = 4'd13;
    localparam logic [3:0] OP_ILL14 = 4'd14;
    localparam logic [3:0] OP_ILL15 = 4'd15;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_BALRZ = 6'b010110;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_JMADD = 6'b110010;

    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BN    = 6'b100101;
    localparam logic [5:0] OPC_JRSAL = 6'b011001;
    localparam logic [5:0] OPC_BALMN = 6'b100100;

endpackage

// File: rtl/instr_format.sv
// rtl/instr_format.sv - combinational op/field to 32-bit instruction word encoder
module instr_format
    import instr_encoder_pkg::*;
(
    input  logic [3:0]        op_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [15:0]       imm_i,
    output logic [DATA_W-1:0] word_o,
    output logic              illegal_o
);

    fmt_e       fmt;
    logic [5:0] code;

    always_comb begin
        fmt       = FMT_R;
        code      = 6'b000000;
        illegal_o = 1'b0;
        case (op_i)
            OP_ADD:   code = F_ADD;
            OP_SUB:   code = F_SUB;
            OP_AND:   code = F_AND;
            OP_OR:    code = F_OR;
            OP_SLT:   code = F_SLT;
            OP_BALRZ: code = F_BALRZ;
            OP_JR:    code = F_JR;
            OP_JMADD: code = F_JMADD;
            OP_LW:    begin fmt = FMT_I; code = OPC_LW;    end
            OP_SW:    begin fmt = FMT_I; code = OPC_SW;    end
            OP_BEQ:   begin fmt = FMT_I; code = OPC_BEQ;   end
            OP_BN:    begin fmt = FMT_I; code = OPC_BN;    end
            OP_JRSAL: begin fmt = FMT_I; code = OPC_JRSAL; end
            OP_BALMN: begin fmt = FMT_I; code = OPC_BALMN; end
            default:  illegal_o = 1'b1;
        endcase
    end

    // R-format carries the selector in funct with a zero opcode; I-format carries it in the opcode
    assign word_o = (fmt == FMT_R) ? {6'b000000, rs_i, rt_i, rd_i, 5'b00000, code}
                                   : {code, rs_i, rt_i, imm_i};

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes requests into a 4-deep write queue feeding instruction memory
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    input  logic              load_base,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ack,
    output logic              err_illegal,
    output logic [7:0]        wr_count
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        count_q, count_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] enc_word;
    logic              enc_illegal;
    logic              accept, push, pop;

    instr_format u_format (
        .op_i      (req_op),
        .rs_i      (req_rs),
        .rt_i      (req_rt),
        .rd_i      (req_rd),
        .imm_i     (req_imm),
        .word_o    (enc_word),
        .illegal_o (enc_illegal)
    );

    // Ready depends only on registered occupancy, so a pop while full frees a slot one cycle later
    assign req_ready = ~reset & (cnt_q != CNT_W'(FIFO_DEPTH));
    assign accept    = req_valid & req_ready;
    assign push      = accept & ~enc_illegal;
    assign wr_en     = (cnt_q != '0);
    assign pop       = wr_en & wr_ack;

    assign wr_addr     = addr_q;
    assign wr_data     = wr_en ? mem_q[rd_ptr_q] : '0;
    assign err_illegal = err_q;
    assign wr_count    = count_q;

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
        if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
        addr_d = addr_q;
        if (pop)
            addr_d = addr_q + ADDR_W'(1);
        else if (load_base && !wr_en)
            addr_d = base_addr;
        count_d = (pop && count_q != 8'hFF) ? count_q + 8'd1 : count_q;
        err_d   = err_q | (accept & enc_illegal);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Payload storage needs no reset: wr_data is masked while the queue is empty
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= enc_word;
    end

endmodule
